// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
// Macro LED_SEQ_PONG_EN adds the ping-pong states and maps mode 11 to them.
package led_seq_pkg;

   // Rate limit Rn = 2^(NB_COUNTER - RATE_EXP_OFSn) - 1
   localparam int unsigned RATE_EXP_OFS0 = 10;
   localparam int unsigned RATE_EXP_OFS1 = 11;
   localparam int unsigned RATE_EXP_OFS2 = 12;
   localparam int unsigned RATE_EXP_OFS3 = 13;

   typedef enum logic [1:0] {
      MODE_SHL   = 2'b00,
      MODE_SHR   = 2'b01,
      MODE_FLASH = 2'b10,
      MODE_PONG  = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHL     = 3'd1,
      ST_SHR     = 3'd2,
      ST_FLASH   = 3'd3
`ifdef LED_SEQ_PONG_EN
      ,
      ST_PONG_UP = 3'd4,
      ST_PONG_DN = 3'd5
`endif
   } state_e;

   // Without ping-pong support, mode 11 falls back to shift-left.
   function automatic state_e mode_to_state(input mode_e mode);
      state_e st;
      st = ST_SHL;
      case (mode)
         MODE_SHR:   st = ST_SHR;
         MODE_FLASH: st = ST_FLASH;
`ifdef LED_SEQ_PONG_EN
         MODE_PONG:  st = ST_PONG_UP;
`endif
         default:    st = ST_SHL;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/led_sequencer_rate_tick.sv
// Free-running rate counter producing a registered one-cycle tick every limit+1
// enabled cycles; the limit is chosen from four power-of-two rates.
module rate_tick
   import led_seq_pkg::*;
#(
   parameter int NB_COUNTER = 32
) (
   input  logic       clock,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic [1:0] i_rate,
   input  logic       i_clear,
   output logic       o_tick
);

   logic [NB_COUNTER-1:0] count_q, count_d;
   logic [NB_COUNTER-1:0] limit;
   logic                  tick_q, tick_d;

   always_comb begin
      limit = {NB_COUNTER{1'b1}} >> RATE_EXP_OFS0;
      case (i_rate)
         2'd0:    limit = {NB_COUNTER{1'b1}} >> RATE_EXP_OFS0;
         2'd1:    limit = {NB_COUNTER{1'b1}} >> RATE_EXP_OFS1;
         2'd2:    limit = {NB_COUNTER{1'b1}} >> RATE_EXP_OFS2;
         default: limit = {NB_COUNTER{1'b1}} >> RATE_EXP_OFS3;
      endcase
   end

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      tick_d  = tick_q;
      if (i_clear) begin
         count_d = '0;
         tick_d  = 1'b0;
      end else if (i_enable) begin
         // >= so that switching to a smaller limit mid-count fires at once
         if (count_q >= limit) begin
            count_d = '0;
            tick_d  = 1'b1;
         end else begin
            count_d = count_q + NB_COUNTER'(1);
            tick_d  = 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments and a synchronous reset sampled on clock.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign o_tick = tick_q;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: shift-left, shift-right, flash and (with LED_SEQ_PONG_EN)
// ping-pong patterns stepped by the rate_tick pulse.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int NB_LEDS    = 4,
   parameter int NB_COUNTER = 32
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic [2:0]         i_sw,
   input  logic [1:0]         i_mode,
   input  logic               i_mode_load,
   output logic [NB_LEDS-1:0] o_led,
   output logic               o_tick,
   output logic [2:0]         o_state
);

   state_e             state_q, state_d;
   logic [NB_LEDS-1:0] led_q, led_d;
   logic               tick;
   logic               run;

   // Idle never counts, so no tick can appear until a mode is loaded.
   assign run = i_sw[0] && (state_q != ST_IDLE);

   rate_tick #(
      .NB_COUNTER (NB_COUNTER)
   ) u_rate_tick (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (run),
      .i_rate   (i_sw[2:1]),
      .i_clear  (i_mode_load),
      .o_tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      if (i_mode_load) begin
         // A load wins over a coincident tick; the tick is discarded.
         state_d = mode_to_state(mode_e'(i_mode));
         case (state_d)
            ST_SHR:   led_d = {1'b1, {(NB_LEDS-1){1'b0}}};
            ST_FLASH: led_d = '0;
            default:  led_d = NB_LEDS'(1);
         endcase
      end else if (run && tick) begin
         case (state_q)
            ST_SHL:     led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
            ST_SHR:     led_d = {led_q[0], led_q[NB_LEDS-1:1]};
            ST_FLASH:   led_d = ~led_q;
`ifdef LED_SEQ_PONG_EN
            ST_PONG_UP: begin
               led_d = led_q << 1;
               if (led_d[NB_LEDS-1]) state_d = ST_PONG_DN;
            end
            ST_PONG_DN: begin
               led_d = led_q >> 1;
               if (led_d[0]) state_d = ST_PONG_UP;
            end
`endif
            default:    led_d = led_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
      end
   end

   assign o_led   = led_q;
   assign o_tick  = tick;
   assign o_state = state_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer (NB_LEDS=4, NB_COUNTER=14) with a
// position/phase based reference model; honours LED_SEQ_PONG_EN like the RTL.
module tb_led_sequencer;

   localparam int NB_LEDS    = 4;
   localparam int NB_COUNTER = 14;

   logic               clock = 1'b0;
   logic               i_reset = 1'b1;
   logic [2:0]         i_sw = 3'b000;
   logic [1:0]         i_mode = 2'b00;
   logic               i_mode_load = 1'b0;
   logic [NB_LEDS-1:0] o_led;
   logic               o_tick;
   logic [2:0]         o_state;

   led_sequencer #(
      .NB_LEDS    (NB_LEDS),
      .NB_COUNTER (NB_COUNTER)
   ) dut (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_sw        (i_sw),
      .i_mode      (i_mode),
      .i_mode_load (i_mode_load),
      .o_led       (o_led),
      .o_tick      (o_tick),
      .o_state     (o_state)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] led;
      logic       tick;
      logic [2:0] state;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [3:0] hist[$];
   int         tick_cyc[$];
   logic [3:0] prev_led = 4'h0;

   // Reference model: pattern kept as a position / phase, not as LED bits.
   int m_cnt  = 0;
   bit m_tick = 1'b0;
   int m_mode = 0;   // 0 idle, 1 shl, 2 shr, 3 flash, 4 ping-pong
   int m_pos  = 0;
   bit m_on   = 1'b0;
   int m_s    = 0;   // ping-pong step along a 2*N-2 long bounce

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      int   p;
      e.tick = m_tick;
      case (m_mode)
         0: begin e.led = 4'h0; e.state = 3'd0; end
         1: begin e.led = 4'(1 << m_pos); e.state = 3'd1; end
         2: begin e.led = 4'(1 << m_pos); e.state = 3'd2; end
         3: begin e.led = m_on ? 4'hF : 4'h0; e.state = 3'd3; end
         default: begin
            p       = (m_s < NB_LEDS) ? m_s : 2*NB_LEDS - 2 - m_s;
            e.led   = 4'(1 << p);
            e.state = (m_s < NB_LEDS - 1) ? 3'd4 : 3'd5;
         end
      endcase
      return e;
   endfunction

   task automatic model_step(input bit rst, input logic [2:0] sw, input logic [1:0] mode, input bit load);
      int limit;
      if (rst) begin
         m_cnt = 0; m_tick = 1'b0; m_mode = 0;
      end else if (load) begin
         m_cnt = 0; m_tick = 1'b0;
         case (mode)
            2'd0: begin m_mode = 1; m_pos = 0; end
            2'd1: begin m_mode = 2; m_pos = NB_LEDS - 1; end
            2'd2: begin m_mode = 3; m_on = 1'b0; end
            default: begin
`ifdef LED_SEQ_PONG_EN
               m_mode = 4; m_s = 0;
`else
               m_mode = 1; m_pos = 0;
`endif
            end
         endcase
      end else if (sw[0] && m_mode != 0) begin
         limit = (1 << (NB_COUNTER - 10 - int'(sw[2:1]))) - 1;
         if (m_tick) begin
            case (m_mode)
               1: m_pos = (m_pos + 1) % NB_LEDS;
               2: m_pos = (m_pos + NB_LEDS - 1) % NB_LEDS;
               3: m_on = !m_on;
               default: m_s = (m_s + 1) % (2*NB_LEDS - 2);
            endcase
         end
         if (m_cnt >= limit) begin
            m_cnt = 0; m_tick = 1'b1;
         end else begin
            m_cnt++; m_tick = 1'b0;
         end
      end
   endtask

   // One clock of stimulus: drive on the falling edge and queue the expectation.
   task automatic drive(input bit rst, input logic [2:0] sw, input logic [1:0] mode, input bit load);
      @(negedge clock);
      i_reset     = rst;
      i_sw        = sw;
      i_mode      = mode;
      i_mode_load = load;
      model_step(rst, sw, mode, load);
      exp_q.push_back(model_out());
   endtask

   task automatic phase_start(input logic [2:0] sw);
      drive(1'b1, sw, 2'b01, 1'b1);
      drive(1'b1, sw, 2'b00, 1'b0);
      hist.delete();
      tick_cyc.delete();
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   // Monitor: compares every registered output against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         cyc++;
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_led", 32'(o_led), 32'(e.led));
            check("sb_tick", 32'(o_tick), 32'(e.tick));
            check("sb_state", 32'(o_state), 32'(e.state));
         end
         if (o_led !== prev_led) begin
            hist.push_back(o_led);
            prev_led = o_led;
         end
         if (o_tick === 1'b1) tick_cyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] t028 [5];
      logic [3:0] t029 [5];
      logic [3:0] t030 [8];
      logic [2:0] sw;
      logic [1:0] mode;
      bit         rst, load;

      // Reset state, with a load strobe that reset must override
      phase_start(3'b111);
      settle();
      check("reset_led", 32'(o_led), 32'h0);
      check("reset_state", 32'(o_state), 32'h0);
      check("reset_tick", 32'(o_tick), 32'h0);

      // Shift-left at R3
      t028 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      phase_start(3'b111);
      drive(1'b0, 3'b111, 2'b00, 1'b1);
      repeat (12) drive(1'b0, 3'b111, 2'b00, 1'b0);
      settle();
      check("shl_hist_len", 32'(hist.size() >= 5), 32'h1);
      for (int i = 0; i < 5; i++) check("shl_seq", 32'(hist[i]), 32'(t028[i]));
      check("shl_tick_period", 32'(tick_cyc[1] - tick_cyc[0]), 32'd2);

      // Shift-right at R0
      t029 = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8};
      phase_start(3'b001);
      drive(1'b0, 3'b001, 2'b01, 1'b1);
      repeat (75) drive(1'b0, 3'b001, 2'b01, 1'b0);
      settle();
      check("shr_hist_len", 32'(hist.size() >= 5), 32'h1);
      for (int i = 0; i < 5; i++) check("shr_seq", 32'(hist[i]), 32'(t029[i]));
      check("shr_tick_count", 32'(tick_cyc.size() >= 4), 32'h1);
      for (int i = 1; i < 4; i++) check("shr_tick_period", 32'(tick_cyc[i] - tick_cyc[i-1]), 32'd16);

      // Mode 11: ping-pong when enabled, shift-left otherwise
`ifdef LED_SEQ_PONG_EN
      t030 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
`else
      t030 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
`endif
      phase_start(3'b111);
      drive(1'b0, 3'b111, 2'b11, 1'b1);
      repeat (18) drive(1'b0, 3'b111, 2'b11, 1'b0);
      settle();
      check("mode3_hist_len", 32'(hist.size() >= 8), 32'h1);
      for (int i = 0; i < 8; i++) check("mode3_seq", 32'(hist[i]), 32'(t030[i]));

      // Flash at R2 with a 20-cycle freeze in the middle
      phase_start(3'b101);
      drive(1'b0, 3'b101, 2'b10, 1'b1);
      repeat (9) drive(1'b0, 3'b101, 2'b10, 1'b0);
      repeat (20) drive(1'b0, 3'b100, 2'b10, 1'b0);
      repeat (20) drive(1'b0, 3'b101, 2'b10, 1'b0);

      // Load coincident with a tick: new seed, no shift
      phase_start(3'b111);
      drive(1'b0, 3'b111, 2'b00, 1'b1);
      for (int i = 0; i < 10 && !m_tick; i++) drive(1'b0, 3'b111, 2'b00, 1'b0);
      settle();
      check("coinc_tick_pre", 32'(o_tick), 32'h1);
      drive(1'b0, 3'b111, 2'b01, 1'b1);
      settle();
      check("coinc_seed_led", 32'(o_led), 32'h8);
      check("coinc_state", 32'(o_state), 32'h2);
      repeat (5) drive(1'b0, 3'b111, 2'b01, 1'b0);

      // Reset in the middle of flashing, then no load
      drive(1'b0, 3'b111, 2'b10, 1'b1);
      repeat (7) drive(1'b0, 3'b111, 2'b10, 1'b0);
      drive(1'b1, 3'b111, 2'b10, 1'b0);
      drive(1'b0, 3'b111, 2'b10, 1'b0);
      tick_cyc.delete();
      repeat (30) drive(1'b0, 3'b111, 2'b10, 1'b0);
      settle();
      check("rst_mid_led", 32'(o_led), 32'h0);
      check("rst_mid_state", 32'(o_state), 32'h0);
      check("rst_mid_no_ticks", 32'(tick_cyc.size()), 32'h0);

      // Counter at 10 under R0, then switch to R3
      phase_start(3'b001);
      drive(1'b0, 3'b001, 2'b00, 1'b1);
      repeat (10) drive(1'b0, 3'b001, 2'b00, 1'b0);
      drive(1'b0, 3'b111, 2'b00, 1'b0);
      settle();
      check("rate_drop_tick", 32'(o_tick), 32'h1);
      repeat (6) drive(1'b0, 3'b111, 2'b00, 1'b0);

      // Randomized traffic against the model
      sw   = 3'b111;
      mode = 2'b00;
      drive(1'b0, sw, mode, 1'b1);
      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 199) == 0);
         load = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 39) == 0)
            sw = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)};
         mode = 2'($urandom_range(0, 3));
         drive(rst, sw, mode, load);
      end

      drive(1'b0, sw, mode, 1'b0);
      settle();
      settle();
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
